// File: rtl/wb_dst_track.sv
// Write-back destination tracker: shifts the ID destination through ID/EX, EX/MEM and MEM/WB
// and derives the busy-register mask, stall cycle counter and stall watchdog flag for hazard detection.
module wb_dst_track #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_dst,
    input  logic             id_wrt,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             halt,
    output logic [3:0]       id_ex_wb_dst,
    output logic             id_ex_wrt,
    output logic [3:0]       ex_mem_wb_dst,
    output logic             ex_mem_wrt,
    output logic [3:0]       mem_wb_dst,
    output logic             mem_wb_wrt,
    output logic [15:0]      busy_mask,
    output logic             pipe_empty,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_err
);

    // Run counter only needs to reach MAX_STALL; one extra bit keeps saturation well above it.
    localparam int RUN_W = $clog2(MAX_STALL + 2) + 1;

    logic [3:0]       id_ex_dst_r;
    logic             id_ex_wrt_r;
    logic [3:0]       ex_mem_dst_r;
    logic             ex_mem_wrt_r;
    logic [3:0]       mem_wb_dst_r;
    logic             mem_wb_wrt_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [RUN_W-1:0] run_cnt_r;
    logic             stall_err_r;
    logic             bubble_s;
    logic [15:0]      busy_mask_s;

    function automatic logic [15:0] dst_onehot(input logic [3:0] dst, input logic wrt);
        logic [15:0] oh;
        oh = 16'h0000;
        if (wrt) begin
            oh[dst] = 1'b1;
        end else begin
            oh = 16'h0000;
        end
        return oh;
    endfunction

    // Bubble selection and busy-mask decode of the registered stages.
    always_comb begin
        bubble_s    = stall | flush | ~id_valid;
        busy_mask_s = dst_onehot(id_ex_dst_r, id_ex_wrt_r)
                    | dst_onehot(ex_mem_dst_r, ex_mem_wrt_r)
                    | dst_onehot(mem_wb_dst_r, mem_wb_wrt_r);
    end

    // Stage registers: downstream stages always drain, ID/EX takes a bubble on stall/flush/invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_dst_r  <= 4'd0;
            id_ex_wrt_r  <= 1'b0;
            ex_mem_dst_r <= 4'd0;
            ex_mem_wrt_r <= 1'b0;
            mem_wb_dst_r <= 4'd0;
            mem_wb_wrt_r <= 1'b0;
        end else if (!halt) begin
            mem_wb_dst_r <= ex_mem_dst_r;
            mem_wb_wrt_r <= ex_mem_wrt_r;
            ex_mem_dst_r <= id_ex_dst_r;
            ex_mem_wrt_r <= id_ex_wrt_r;
            if (bubble_s) begin
                id_ex_dst_r <= 4'd0;
                id_ex_wrt_r <= 1'b0;
            end else begin
                id_ex_dst_r <= id_dst;
                id_ex_wrt_r <= id_wrt & (id_dst != 4'd0);
            end
        end
    end

    // Stall statistics: saturating total count, consecutive-run count and sticky watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            run_cnt_r   <= {RUN_W{1'b0}};
            stall_err_r <= 1'b0;
        end else if (!halt) begin
            if (stall) begin
                if (stall_cnt_r != {CNT_W{1'b1}}) begin
                    stall_cnt_r <= stall_cnt_r + CNT_W'(1);
                end
                if (run_cnt_r != {RUN_W{1'b1}}) begin
                    run_cnt_r <= run_cnt_r + RUN_W'(1);
                end
                if (run_cnt_r == RUN_W'(MAX_STALL)) begin
                    stall_err_r <= 1'b1;
                end
            end else begin
                run_cnt_r <= {RUN_W{1'b0}};
            end
        end
    end

    assign id_ex_wb_dst  = id_ex_dst_r;
    assign id_ex_wrt     = id_ex_wrt_r;
    assign ex_mem_wb_dst = ex_mem_dst_r;
    assign ex_mem_wrt    = ex_mem_wrt_r;
    assign mem_wb_dst    = mem_wb_dst_r;
    assign mem_wb_wrt    = mem_wb_wrt_r;
    assign busy_mask     = busy_mask_s;
    assign pipe_empty    = ~(id_ex_wrt_r | ex_mem_wrt_r | mem_wb_wrt_r);
    assign stall_cnt     = stall_cnt_r;
    assign stall_err     = stall_err_r;

endmodule
